// File: rtl/uart_fifo_ctrl_if.sv
// FT245-style FIFO bus, two transmit requester streams and the receive stream of uart_fifo_ctrl.
// slave = controller side, master = SOC/pad side.
interface uart_fifo_ctrl_if;
    logic       txe_n;
    logic       rxf_n;
    logic [7:0] uart_di;
    logic [7:0] uart_do;
    logic       uart_oe;
    logic       uart_wr;
    logic       uart_rd;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       busy;

    modport slave (
        input  txe_n, rxf_n, uart_di, a_valid, a_data, b_valid, b_data, rx_ready,
        output uart_do, uart_oe, uart_wr, uart_rd, a_ready, b_ready, rx_valid, rx_data, busy
    );

    modport master (
        output txe_n, rxf_n, uart_di, a_valid, a_data, b_valid, b_data, rx_ready,
        input  uart_do, uart_oe, uart_wr, uart_rd, a_ready, b_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Purpose: round-robin sequencer (RX->A->B) for an FT245-style FIFO bus; UART_CTRL_STATS_EN adds tx/rx counters.
// Latency: TX grant to wr=1 in 2 cycles, grant-to-grant 3+PULSE_CYC+GAP_CYC (TX) / 1+PULSE_CYC+GAP_CYC (RX).
// Backpressure: TX held off by txe_n, RX held off by rxf_n or a full unconsumed rx_data register.
module uart_fifo_ctrl #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_fifo_ctrl_if.slave   bus
`ifdef UART_CTRL_STATS_EN
    ,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_SETUP = 3'd1;
    localparam logic [2:0] S_WR_PULSE = 3'd2;
    localparam logic [2:0] S_WR_HOLD  = 3'd3;
    localparam logic [2:0] S_RD_PULSE = 3'd4;
    localparam logic [2:0] S_RECOVER  = 3'd5;

    localparam logic [1:0] P_RX = 2'd0;
    localparam logic [1:0] P_A  = 2'd1;
    localparam logic [1:0] P_B  = 2'd2;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] rr_q, rr_d;
    logic [7:0] do_q, do_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;

    logic       elig_rx, elig_a, elig_b;
    logic       grant_vld;
    logic [1:0] grant;
    logic       a_rdy, b_rdy;
    logic       rx_sample;

    assign elig_rx = ~bus.rxf_n & (~rx_valid_q | bus.rx_ready);
    assign elig_a  = bus.a_valid & ~bus.txe_n;
    assign elig_b  = bus.b_valid & ~bus.txe_n;

    // rr_q names the requester with highest priority for the next search.
    always_comb begin
        grant_vld = 1'b1;
        grant     = P_RX;
        case (rr_q)
            P_A: begin
                if (elig_a)       grant = P_A;
                else if (elig_b)  grant = P_B;
                else if (elig_rx) grant = P_RX;
                else              grant_vld = 1'b0;
            end
            P_B: begin
                if (elig_b)       grant = P_B;
                else if (elig_rx) grant = P_RX;
                else if (elig_a)  grant = P_A;
                else              grant_vld = 1'b0;
            end
            default: begin
                if (elig_rx)      grant = P_RX;
                else if (elig_a)  grant = P_A;
                else if (elig_b)  grant = P_B;
                else              grant_vld = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        do_d      = do_q;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        rx_sample = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    rr_d = (grant == P_RX) ? P_A : ((grant == P_A) ? P_B : P_RX);
                    if (grant == P_RX) begin
                        state_d = S_RD_PULSE;
                        cnt_d   = PULSE_LD;
                    end else begin
                        state_d = S_WR_SETUP;
                        a_rdy   = (grant == P_A);
                        b_rdy   = (grant == P_B);
                        do_d    = (grant == P_A) ? bus.a_data : bus.b_data;
                    end
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = PULSE_LD;
            end
            S_WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = S_WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WR_HOLD: begin
                state_d = S_RECOVER;
                cnt_d   = GAP_LD;
            end
            S_RD_PULSE: begin
                if (cnt_q == 4'd0) begin
                    rx_sample = 1'b1;
                    state_d   = S_RECOVER;
                    cnt_d     = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A sample landing in the same cycle as a consume leaves the new byte valid.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        if (rx_sample) begin
            rx_valid_d = 1'b1;
            rx_data_d  = bus.uart_di;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rr_q       <= P_RX;
            do_q       <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            do_q       <= do_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign bus.uart_wr  = (state_q == S_WR_PULSE);
    assign bus.uart_rd  = (state_q == S_RD_PULSE);
    assign bus.uart_oe  = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD);
    assign bus.uart_do  = do_q;
    assign bus.a_ready  = a_rdy;
    assign bus.b_ready  = b_rdy;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = (state_q != S_IDLE);

`ifdef UART_CTRL_STATS_EN
    logic [15:0] tx_count_q, tx_count_d;
    logic [15:0] rx_count_q, rx_count_d;

    always_comb begin
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        if (state_q == S_WR_HOLD) tx_count_d = tx_count_q + 16'd1;
        if (rx_sample)            rx_count_d = rx_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count_q <= 16'd0;
            rx_count_q <= 16'd0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: transaction-timeline reference model compared every cycle, plus directed literal checks.
module tb_uart_fifo_ctrl;
    localparam int P = 4;
    localparam int G = 4;

    logic clk;
    logic rst;
    uart_fifo_ctrl_if bus();

`ifdef UART_CTRL_STATS_EN
    logic [15:0] tx_count, rx_count;
    uart_fifo_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .rst(rst), .bus(bus), .tx_count(tx_count), .rx_count(rx_count));
`else
    uart_fifo_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: active transfer kind (0 none, 1 tx, 2 rx), cycles since its grant, priority index 0=RX 1=A 2=B.
    int       m_act, m_t, m_ptr, m_g, m_txc, m_rxc;
    logic [7:0] m_do, m_rxd;
    logic       m_rxv;

    // Observation counters for directed checks.
    int  wr_cnt, oe_cnt, ardy_cnt, rd_rise, do_bad, first_wr_cyc, ardy_cyc, brdy_cyc;
    logic prev_rd;
    logic last_ardy;
    int  grants[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_t = 0; m_ptr = 0; m_g = -1;
        m_do = 8'd0; m_rxd = 8'd0; m_rxv = 1'b0;
        m_txc = 0; m_rxc = 0;
        prev_rd = 1'b0;
    endtask

    task automatic clear_obs();
        wr_cnt = 0; oe_cnt = 0; ardy_cnt = 0; rd_rise = 0; do_bad = 0;
        first_wr_cyc = -1; ardy_cyc = -1; brdy_cyc = -1;
        grants.delete();
    endtask

    task automatic cycle();
        logic e[3];
        logic [7:0] ad, bd, di;
        logic rr;
        int   idx;
        @(negedge clk);
        e[0] = !bus.rxf_n && (!m_rxv || bus.rx_ready);
        e[1] = bus.a_valid && !bus.txe_n;
        e[2] = bus.b_valid && !bus.txe_n;
        m_g = -1;
        if (m_act == 0) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (m_g < 0 && e[idx]) m_g = idx;
            end
        end
        check("a_ready",  int'(bus.a_ready),  int'(m_g == 1));
        check("b_ready",  int'(bus.b_ready),  int'(m_g == 2));
        check("uart_wr",  int'(bus.uart_wr),  int'(m_act == 1 && m_t >= 2 && m_t < 2 + P));
        check("uart_oe",  int'(bus.uart_oe),  int'(m_act == 1 && m_t >= 1 && m_t <= P + 2));
        check("uart_rd",  int'(bus.uart_rd),  int'(m_act == 2 && m_t >= 1 && m_t <= P));
        check("busy",     int'(bus.busy),     int'(m_act != 0));
        check("uart_do",  int'(bus.uart_do),  int'(m_do));
        check("rx_valid", int'(bus.rx_valid), int'(m_rxv));
        check("rx_data",  int'(bus.rx_data),  int'(m_rxd));
        if (bus.uart_oe && bus.uart_rd) check("oe_rd_contention", 1, 0);
`ifdef UART_CTRL_STATS_EN
        check("tx_count", int'(tx_count), m_txc & 16'hFFFF);
        check("rx_count", int'(rx_count), m_rxc & 16'hFFFF);
`endif
        if (bus.uart_wr) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (bus.uart_oe) oe_cnt++;
        if (bus.uart_oe && bus.uart_do != 8'h5A) do_bad++;
        if (bus.a_ready) begin ardy_cnt++; grants.push_back(1); if (ardy_cyc < 0) ardy_cyc = cyc; end
        if (bus.b_ready) begin grants.push_back(2); if (brdy_cyc < 0) brdy_cyc = cyc; end
        if (bus.uart_rd && !prev_rd) begin rd_rise++; grants.push_back(0); end
        prev_rd   = bus.uart_rd;
        last_ardy = bus.a_ready;
        ad = bus.a_data; bd = bus.b_data; di = bus.uart_di; rr = bus.rx_ready;
        @(posedge clk);
        cyc++;
        if (m_rxv && rr) m_rxv = 1'b0;
        if (m_act == 2 && m_t == P) begin m_rxv = 1'b1; m_rxd = di; m_rxc++; end
        if (m_act == 1 && m_t == P + 2) m_txc++;
        if (m_act != 0) begin
            m_t++;
            if (m_t == ((m_act == 1) ? 3 + P + G : 1 + P + G)) m_act = 0;
        end else if (m_g >= 0) begin
            m_act = (m_g == 0) ? 2 : 1;
            m_t   = 1;
            m_ptr = (m_g + 1) % 3;
            if (m_g == 1) m_do = ad;
            else if (m_g == 2) m_do = bd;
        end
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_wr", int'(bus.uart_wr), 0);
        check("rst_oe", int'(bus.uart_oe), 0);
        check("rst_rd", int'(bus.uart_rd), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rx_valid", int'(bus.rx_valid), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && m_act != 0; i++) cycle();
        check("idle_timeout", m_act, 0);
    endtask

    logic [7:0] exp_q[6];

    initial begin
        rst = 1'b0;
        bus.txe_n = 1'b1; bus.rxf_n = 1'b1; bus.uart_di = 8'h00;
        bus.a_valid = 1'b0; bus.a_data = 8'h00;
        bus.b_valid = 1'b0; bus.b_data = 8'h00;
        bus.rx_ready = 1'b0;
        model_reset();
        clear_obs();
        @(posedge clk); #2;
        do_reset();

        // Single TX of 8'h5A from A.
        clear_obs();
        bus.txe_n = 1'b0; bus.a_valid = 1'b1; bus.a_data = 8'h5A;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (m_g == 1) bus.a_valid = 1'b0;
        end
        check("tx_a_ready_cycles", ardy_cnt, 1);
        check("tx_wr_cycles", wr_cnt, 4);
        check("tx_oe_cycles", oe_cnt, 6);
        check("tx_do_stable", do_bad, 0);
        check("tx_grant_to_wr", first_wr_cyc - ardy_cyc, 2);

        // Reset during WR_PULSE.
        bus.a_valid = 1'b1; bus.a_data = 8'h81;
        for (int i = 0; i < 30 && !(m_act == 1 && m_t == 3); i++) begin
            cycle();
            if (m_g == 1) bus.a_valid = 1'b0;
        end
        check("pre_rst_wr", int'(bus.uart_wr), 1);
        do_reset();

        // Full contention after reset: RX, A, B, RX, A, B.
        clear_obs();
        bus.txe_n = 1'b0; bus.rxf_n = 1'b0; bus.rx_ready = 1'b1;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.a_data = 8'h11; bus.b_data = 8'h22;
        for (int i = 0; i < 100 && grants.size() < 6; i++) begin
            bus.uart_di = 8'($urandom);
            cycle();
        end
        check("rr_grant_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            check("rr_order", grants[i], i % 3);
        check("rr_a_to_b_gap", brdy_cyc - ardy_cyc, 3 + P + G);

        bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.rxf_n = 1'b1;
        wait_idle();
        cycle();

        // RX backpressure: one read only while rx_data is unconsumed.
        clear_obs();
        bus.rxf_n = 1'b0; bus.rx_ready = 1'b0; bus.uart_di = 8'hC3;
        for (int i = 0; i < 40; i++) cycle();
        check("rx_bp_reads", rd_rise, 1);
        check("rx_bp_data", int'(bus.rx_data), 8'hC3);
        check("rx_bp_valid", int'(bus.rx_valid), 1);
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("rx_resume", int'(rd_rise > 1), 1);
        bus.rxf_n = 1'b1;
        wait_idle();

        // Flow control on txe_n.
        clear_obs();
        bus.txe_n = 1'b1; bus.a_valid = 1'b1; bus.a_data = 8'h3C;
        for (int i = 0; i < 20; i++) cycle();
        check("fc_no_ready", ardy_cnt, 0);
        check("fc_no_wr", wr_cnt, 0);
        bus.txe_n = 1'b0;
        cycle();
        check("fc_ready_on_txe", int'(last_ardy), 1);
        bus.a_valid = 1'b0;
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.txe_n    = ($urandom_range(0, 3) == 0);
            bus.rxf_n    = ($urandom_range(0, 2) == 0);
            bus.rx_ready = ($urandom_range(0, 1) == 0);
            bus.uart_di  = 8'($urandom);
            if (!bus.a_valid && $urandom_range(0, 2) == 0) begin
                bus.a_valid = 1'b1; bus.a_data = 8'($urandom);
            end
            if (!bus.b_valid && $urandom_range(0, 2) == 0) begin
                bus.b_valid = 1'b1; bus.b_data = 8'($urandom);
            end
            cycle();
            if (m_g == 1) bus.a_valid = 1'b0;
            if (m_g == 2) bus.b_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
